// File: rtl/regfile_seq_ctrl_if.sv
// Control bus between the instruction source, the sequencer and the datapath.
// Master issues instructions; slave (the sequencer) drives regfile/datapath control.
interface regfile_seq_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
);
    logic              s;
    logic              load;
    logic [DATA_W-1:0] in;
    logic [REG_AW-1:0] readnum;
    logic [REG_AW-1:0] writenum;
    logic              write;
    logic              loada;
    logic              loadb;
    logic              loadc;
    logic              loads;
    logic              asel;
    logic              vsel;
    logic [1:0]        shift;
    logic [1:0]        ALUop;
    logic [DATA_W-1:0] sximm8;
    logic              w;
    logic              illegal;

    modport master (
        output s, load, in,
        input  readnum, writenum, write, loada, loadb, loadc, loads,
        input  asel, vsel, shift, ALUop, sximm8, w, illegal
    );

    modport slave (
        input  s, load, in,
        output readnum, writenum, write, loada, loadb, loadc, loads,
        output asel, vsel, shift, ALUop, sximm8, w, illegal
    );
endinterface

// File: rtl/regfile_seq_ctrl.sv
// Simple RISC Machine sequencer: latches IR, steps a Moore FSM over regfile/datapath.
// Define ILLEGAL_TRAP_EN to halt on undefined opcodes with a sticky illegal flag.
module regfile_seq_ctrl #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              reset,
    regfile_seq_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_CMP,
        S_WR_REG,
        S_WR_IMM,
        S_HALT
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;

    logic [2:0]        opcode;
    logic [1:0]        op;
    logic [REG_AW-1:0] rn, rd, rm;
    logic              is_movi, is_movr, is_mvn, is_cmp, is_arith;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[8 +: REG_AW];
    assign rd     = ir_q[5 +: REG_AW];
    assign rm     = ir_q[0 +: REG_AW];

    assign is_movi  = (opcode == 3'b110) && (op == 2'b10);
    assign is_movr  = (opcode == 3'b110) && (op == 2'b00);
    assign is_mvn   = (opcode == 3'b101) && (op == 2'b11);
    assign is_cmp   = (opcode == 3'b101) && (op == 2'b01);
    assign is_arith = (opcode == 3'b101) && !op[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        bus.readnum  = rn;
        bus.writenum = rn;
        bus.write    = 1'b0;
        bus.loada    = 1'b0;
        bus.loadb    = 1'b0;
        bus.loadc    = 1'b0;
        bus.loads    = 1'b0;
        bus.asel     = 1'b0;
        bus.vsel     = 1'b0;
        unique case (state_q)
            S_WAIT: begin
                if (bus.load) ir_d = bus.in;
                if (bus.s) state_d = S_DECODE;
            end
            S_DECODE: begin
                unique case (1'b1)
                    is_movi:            state_d = S_WR_IMM;
                    is_movr, is_mvn:    state_d = S_GET_B;
                    is_cmp, is_arith:   state_d = S_GET_A;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d = S_HALT;
`else
                        state_d = S_WAIT;
`endif
                    end
                endcase
            end
            S_GET_A: begin
                bus.loada = 1'b1;
                state_d   = S_GET_B;
            end
            S_GET_B: begin
                bus.readnum = rm;
                bus.loadb   = 1'b1;
                state_d     = is_cmp ? S_CMP : S_ALU;
            end
            S_ALU: begin
                bus.loadc = 1'b1;
                bus.asel  = is_movr | is_mvn;
                state_d   = S_WR_REG;
            end
            S_CMP: begin
                bus.loads = 1'b1;
                state_d   = S_WAIT;
            end
            S_WR_REG: begin
                bus.writenum = rd;
                bus.write    = 1'b1;
                state_d      = S_WAIT;
            end
            S_WR_IMM: begin
                bus.vsel  = 1'b1;
                bus.write = 1'b1;
                state_d   = S_WAIT;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_WAIT;
        endcase
        // Reset mid-instruction must never commit a write or load.
        if (reset) begin
            bus.write = 1'b0;
            bus.loada = 1'b0;
            bus.loadb = 1'b0;
            bus.loadc = 1'b0;
            bus.loads = 1'b0;
        end
    end

    assign bus.w      = (state_q == S_WAIT);
    assign bus.shift  = ir_q[4:3];
    assign bus.ALUop  = (opcode == 3'b101) ? op : 2'b00;
    assign bus.sximm8 = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
    logic is_undef;

    assign is_undef = !(is_movi | is_movr | is_mvn | is_cmp | is_arith);

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (state_q == S_DECODE && is_undef) begin
            illegal_q <= 1'b1;
        end
    end

    assign bus.illegal = illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Bench for regfile_seq_ctrl: directed vector table, corner sequences,
// and random instructions checked against a per-instruction micro-step model.
module tb_regfile_seq_ctrl;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  regfile_seq_ctrl_if #(.DATA_W(16), .REG_AW(3)) bus ();

  regfile_seq_ctrl #(.DATA_W(16), .REG_AW(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic       w;
    logic [2:0] rn;
    logic [2:0] wn;
    logic       wr;
    logic       la;
    logic       lb;
    logic       lc;
    logic       ls;
    logic       ac;
    logic       asel;
    logic       vc;
    logic       vsel;
  } exp_t;

  typedef struct {
    logic [15:0] ir;
    int          lat;
    bit          sep;
  } vec_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic exp_t idle_rec(input logic [15:0] ir);
    exp_t e;
    e    = '0;
    e.rn = ir[10:8];
    e.wn = ir[10:8];
    return e;
  endfunction

  // Expected cycle list after the edge that samples s: one entry per
  // register access, ending with the return to idle.
  task automatic build(input logic [15:0] ir);
    exp_t       e;
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op;
    bit         uses_a, is_cmp;
    opc = ir[15:13];
    op  = ir[12:11];
    rn  = ir[10:8];
    rd  = ir[7:5];
    rm  = ir[2:0];
    exp_q.delete();
    exp_q.push_back(idle_rec(ir));
    if (opc == 3'b110 && op == 2'b10) begin
      e      = idle_rec(ir);
      e.wn   = rn;
      e.wr   = 1'b1;
      e.vc   = 1'b1;
      e.vsel = 1'b1;
      exp_q.push_back(e);
    end else if ((opc == 3'b110 && op == 2'b00) || opc == 3'b101) begin
      uses_a = (opc == 3'b101) && (op != 2'b11);
      is_cmp = (opc == 3'b101) && (op == 2'b01);
      if (uses_a) begin
        e    = idle_rec(ir);
        e.rn = rn;
        e.la = 1'b1;
        exp_q.push_back(e);
      end
      e    = idle_rec(ir);
      e.rn = rm;
      e.lb = 1'b1;
      exp_q.push_back(e);
      e    = idle_rec(ir);
      e.ac = 1'b1;
      if (is_cmp) begin
        e.ls = 1'b1;
        exp_q.push_back(e);
      end else begin
        e.lc   = 1'b1;
        e.asel = !uses_a;
        exp_q.push_back(e);
        e      = idle_rec(ir);
        e.wn   = rd;
        e.wr   = 1'b1;
        e.vc   = 1'b1;
        exp_q.push_back(e);
      end
    end
    e   = idle_rec(ir);
    e.w = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic cmp_cycle(input string tag, input int k,
                           input logic [15:0] ir, input exp_t e);
    string p;
    p = $sformatf("%s c%0d", tag, k);
    chk({p, " ctl"},
        {21'd0, bus.w, bus.readnum, bus.writenum, bus.write,
         bus.loada, bus.loadb, bus.loadc, bus.loads},
        {21'd0, e.w, e.rn, e.wn, e.wr, e.la, e.lb, e.lc, e.ls});
    if (e.ac) chk({p, " asel"}, 32'(bus.asel), 32'(e.asel));
    if (e.vc) chk({p, " vsel"}, 32'(bus.vsel), 32'(e.vsel));
    if (ir[15:13] == 3'b101)
      chk({p, " aluop"}, 32'(bus.ALUop), 32'(ir[12:11]));
    else if (ir[15:13] == 3'b110)
      chk({p, " aluop"}, 32'(bus.ALUop), 32'd0);
    chk({p, " shift"}, 32'(bus.shift), 32'(ir[4:3]));
    chk({p, " sximm8"}, 32'(bus.sximm8), 32'({{8{ir[7]}}, ir[7:0]}));
    chk({p, " illegal"}, 32'(bus.illegal), 32'd0);
  endtask

  task automatic run_instr(input string tag, input logic [15:0] ir,
                           input bit sep, input bit noise,
                           output int lat);
    build(ir);
    if (sep) begin
      bus.load = 1'b1;
      bus.in   = ir;
      bus.s    = 1'b0;
      step();
      bus.load = 1'b0;
      chk({tag, " preload w"}, 32'(bus.w), 32'd1);
    end
    bus.load = !sep;
    bus.in   = ir;
    bus.s    = 1'b1;
    step();
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      lat = k;
      if (k <= exp_q.size())
        cmp_cycle(tag, k, ir, exp_q[k-1]);
      else
        chk({tag, " overrun"}, 32'(k), 32'(exp_q.size()));
      if (bus.w) break;
      if (k == 20) chk({tag, " timeout"}, 32'(bus.w), 32'd1);
      if (noise) begin
        bus.s    = 1'($urandom);
        bus.load = 1'($urandom);
        bus.in   = 16'($urandom);
      end else begin
        bus.s    = 1'b0;
        bus.load = 1'b0;
      end
      step();
    end
    bus.s    = 1'b0;
    bus.load = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'(exp_q.size()));
  endtask

  vec_t        tbl[7];
  int          lat;
  logic [15:0] ir;
  logic [12:0] r;
  int          cls;
  int          sel;

  initial begin
    tbl[0] = '{16'hD007, 3, 1'b0};
    tbl[1] = '{16'hA140, 6, 1'b1};
    tbl[2] = '{16'hC028, 5, 1'b0};
    tbl[3] = '{16'hB862, 5, 1'b1};
    tbl[4] = '{16'hA900, 5, 1'b0};
    tbl[5] = '{16'hB162, 6, 1'b0};
    tbl[6] = '{16'hD2F0, 3, 1'b1};

    reset    = 1'b1;
    bus.s    = 1'b0;
    bus.load = 1'b0;
    bus.in   = 16'h0;
    step();
    step();
    reset = 1'b0;
    chk("rst w", 32'(bus.w), 32'd1);
    chk("rst strobes",
        {27'd0, bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads},
        32'd0);
    chk("rst sximm8", 32'(bus.sximm8), 32'd0);
    chk("rst readnum", 32'(bus.readnum), 32'd0);
    chk("rst illegal", 32'(bus.illegal), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_instr($sformatf("vec%0d", i), tbl[i].ir, tbl[i].sep, 1'b0, lat);
      chk($sformatf("vec%0d spec_lat", i), 32'(lat), 32'(tbl[i].lat));
    end

    // Load during GET_A is ignored; reset during WR_REG suppresses write.
    bus.load = 1'b1;
    bus.in   = 16'hA140;
    bus.s    = 1'b1;
    step();
    bus.load = 1'b0;
    bus.s    = 1'b0;
    step();
    chk("seq getA readnum", 32'(bus.readnum), 32'd1);
    chk("seq getA loada", 32'(bus.loada), 32'd1);
    bus.load = 1'b1;
    bus.in   = 16'hFFFF;
    step();
    bus.load = 1'b0;
    chk("seq ir kept", 32'(bus.sximm8), 32'h0040);
    chk("seq getB readnum", 32'(bus.readnum), 32'd0);
    step();
    step();
    chk("seq wrreg write", 32'(bus.write), 32'd1);
    reset = 1'b1;
    #1;
    chk("seq rst write", 32'(bus.write), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("seq rst w", 32'(bus.w), 32'd1);
    chk("seq rst ir", 32'(bus.sximm8), 32'd0);
    chk("seq rst writenum", 32'(bus.writenum), 32'd0);

    for (int n = 0; n < 200; n++) begin
      cls = $urandom_range(0, 5);
      r   = 13'($urandom);
`ifdef ILLEGAL_TRAP_EN
      if (cls == 5) cls = 2;
`endif
      case (cls)
        0: ir = {3'b110, 2'b10, r[10:0]};
        1: ir = {3'b110, 2'b00, r[10:0]};
        2: ir = {3'b101, r};
        3: ir = {3'b101, 2'b01, r[10:0]};
        4: ir = {3'b101, 2'b11, r[10:0]};
        default: begin
          sel = $urandom_range(0, 7);
          if (sel == 5 || sel == 6)
            ir = {3'b110, r[12], 1'b1, r[10:0]};
          else
            ir = {3'(sel), r};
        end
      endcase
      run_instr($sformatf("rnd%0d", n), ir, 1'($urandom), 1'($urandom),
                lat);
    end

`ifdef ILLEGAL_TRAP_EN
    bus.load = 1'b1;
    bus.in   = 16'hE000;
    bus.s    = 1'b1;
    step();
    bus.load = 1'b0;
    bus.s    = 1'b0;
    chk("trap decode w", 32'(bus.w), 32'd0);
    step();
    chk("trap illegal", 32'(bus.illegal), 32'd1);
    for (int k = 0; k < 4; k++) begin
      bus.s    = 1'b1;
      bus.load = 1'b1;
      bus.in   = 16'h00FF;
      step();
      chk($sformatf("trap hold w%0d", k), 32'(bus.w), 32'd0);
      chk($sformatf("trap hold ill%0d", k), 32'(bus.illegal), 32'd1);
      chk($sformatf("trap hold ir%0d", k), 32'(bus.sximm8), 32'd0);
      chk($sformatf("trap strobes%0d", k),
          {27'd0, bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads},
          32'd0);
    end
    bus.s    = 1'b0;
    bus.load = 1'b0;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    chk("trap clr illegal", 32'(bus.illegal), 32'd0);
    chk("trap clr w", 32'(bus.w), 32'd1);
`else
    run_instr("nop", 16'hE000, 1'b0, 1'b0, lat);
    chk("nop spec_lat", 32'(lat), 32'd2);
    chk("nop illegal", 32'(bus.illegal), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_seq_ctrl.md
Name: regfile_seq_ctrl

Overview:
Instruction sequencer for the Simple RISC Machine datapath.
- Latches a 16-bit instruction and decodes it.
- Steps a Moore FSM that drives the register file ports (readnum, writenum, write) and the datapath load/select strobes.
- Each register access happens in its own cycle.
- Sits between the instruction source and the regfile/shifter/ALU datapath. It is the only agent that drives regfile control.

Parameters:
DATA_W, 16, instruction and immediate width
REG_AW, 3, register address width (8 registers)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high; returns FSM to WAIT, clears IR
s  input  1  start execution of IR (sampled only in WAIT)
load  input  1  load `in` into IR (honoured only in WAIT)
in  input  DATA_W  instruction word
readnum  output  REG_AW  regfile read address
writenum  output  REG_AW  regfile write address
write  output  1  regfile write enable
loada  output  1  load datapath A register
loadb  output  1  load datapath B register
loadc  output  1  load datapath C register
loads  output  1  load status flags
asel  output  1  1 = A operand forced to 0
vsel  output  1  regfile write data: 0 = C, 1 = sximm8
shift  output  2  shifter op = IR[4:3]
ALUop  output  2  ALU op
sximm8  output  DATA_W  sign-extended IR[7:0]
w  output  1  1 = idle in WAIT
illegal  output  1  sticky illegal-opcode flag (see Optional Feature)

Behaviour:
- IR fields: opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0].
- Reset: state = WAIT, IR = 0, illegal = 0.
- While reset = 1, write, loada, loadb, loadc and loads are forced to 0 regardless of state, so reset mid-instruction never writes. The next state is WAIT.
- Outputs are combinational from the registered state and IR (Moore). A strobe is high for exactly one cycle per state visit.
- In WAIT: w = 1; all strobes = 0.
- If load = 1, IR <= in at the edge. If s = 1, next state is DECODE.
- If load and s are high together, DECODE uses the newly loaded IR.
- load or s outside WAIT is ignored.
- DECODE: no strobes. Next state:
  - opcode 110, op 10 -> WR_IMM
  - opcode 110, op 00 -> GET_B
  - opcode 101, op 00/10/01 -> GET_A
  - opcode 101, op 11 -> GET_B
  - anything else -> illegal path
- GET_A: readnum = Rn, loada = 1 -> GET_B.
- GET_B: readnum = Rm, loadb = 1. Next state is CMP if the instruction is CMP, else ALU.
- ALU: loadc = 1. For MOV reg and MVN, asel = 1; otherwise asel = 0. -> WR_REG.
- CMP: loads = 1, asel = 0 -> WAIT. CMP never asserts write.
- WR_REG: writenum = Rd, vsel = 0, write = 1 -> WAIT.
- WR_IMM: writenum = Rn, vsel = 1, write = 1 -> WAIT.
- ALUop = op when opcode = 101; 00 for opcode 110.
- shift = sh in every state. sximm8 = {{8{IR[7]}}, IR[7:0]} continuously.
- In states that do not use readnum/writenum, both output Rn.
- Latency, counted as edges from the edge that samples s to the edge on which w returns to 1:
  - MOV imm: 3
  - MOV reg: 5
  - MVN: 5
  - ADD/AND: 6
  - CMP: 5

Optional Feature:
Macro: ILLEGAL_TRAP_EN.
- Defined: an undefined opcode moves DECODE -> HALT and sets illegal = 1 (sticky). HALT has w = 0 and no strobes, ignores s and load, and is left only by reset.
- Undefined: an undefined opcode moves DECODE -> WAIT as a NOP with no strobes; illegal is tied to 0.

Test Plan:
- Load 0xD007 (MOV R0,#7), pulse s -> DECODE, then WR_IMM with write = 1, writenum = 0, vsel = 1, sximm8 = 0x0007; w = 1 three edges after s.
- Load 0xA140 (ADD R2,R1,R0), pulse s -> GET_A (readnum = 1, loada), GET_B (readnum = 0, loadb), ALU (loadc, asel = 0, ALUop = 00), WR_REG (writenum = 2, write, vsel = 0); w = 1 at edge 6.
- 0xC028 (MOV R1,R0,LSL#1) -> GET_B with readnum = 0; ALU with asel = 1, shift = 01, ALUop = 00; WR_REG with writenum = 1. 0xB862 (MVN R3,R2) -> same path with readnum = 2, ALUop = 11, writenum = 3.
- 0xA900 (CMP R1,R0) -> GET_A (readnum = 1), GET_B (readnum = 0), CMP with loads = 1 and ALUop = 01; write = 0 in every cycle; w = 1 at edge 5.
- Assert reset during WR_REG of 0xA140 -> write = 0 that cycle; next cycle WAIT, w = 1, IR = 0. load asserted during GET_A does not change IR.
- Load 0xE000, pulse s -> with ILLEGAL_TRAP_EN: illegal = 1 and w = 0 until reset, and s is ignored. Without it: WAIT after 2 edges, illegal = 0, no strobes.
